piradip_axis_sample_buffer_seq: RTL and testbench

Stream-domain sequencer for a multi-channel sample buffer: per channel it holds a start/end window, steps a sample address on every accepted beat, and wraps or stops according to a per-channel mode. Config arrives as one atomic snapshot, typically from the CDC output of the MM-side CSR. The block sits between that CSR and the sample RAM address ports. It generalises single-channel active/one-shot control to N channels with a triggered-arm mode, wrap-across-zero windows and done/wrap events.

---
 rtl/piradip_sample_buffer_pkg.sv | 7 +
 rtl/piradip_sample_buffer_seq_chan.sv | 75 +++++++
 rtl/piradip_axis_sample_buffer_seq.sv | 41 ++++
 tb/tb_piradip_axis_sample_buffer_seq.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/piradip_sample_buffer_pkg.sv
// piradip_sample_buffer: shared modes and sequencer state encoding for the sample buffer
package piradip_sample_buffer;
  localparam logic [1:0] MODE_CONTINUOUS = 2'd0;
  localparam logic [1:0] MODE_ONE_SHOT   = 2'd1;
  localparam logic [1:0] MODE_TRIGGERED  = 2'd2;
  typedef enum logic [1:0] {IDLE, ARMED, RUN, DONE} seq_state_t;
endpackage

// File: rtl/piradip_sample_buffer_seq_chan.sv
// piradip_sample_buffer_seq_chan: one channel's shadow config, sequencer FSM and address counter
module piradip_sample_buffer_seq_chan
  import piradip_sample_buffer::*;
#(
  parameter int OFFSET_WIDTH = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_update,
  input  logic                    cfg_active,
  input  logic [1:0]              cfg_mode,
  input  logic [OFFSET_WIDTH-1:0] cfg_start_offset,
  input  logic [OFFSET_WIDTH-1:0] cfg_end_offset,
  input  logic                    trigger,
  input  logic                    advance,
  output logic [OFFSET_WIDTH-1:0] addr,
  output logic                    addr_valid,
  output logic                    stopped,
  output logic                    wrapped,
  output logic                    done
);
  seq_state_t state, state_d;
  logic [OFFSET_WIDTH-1:0] addr_d, start_q, end_q;
  logic [1:0] mode_q;
  logic active_q, wrap_d, done_d;
  always_comb begin
    state_d = state;
    addr_d = addr;
    wrap_d = 1'b0;
    done_d = 1'b0;
    if (cfg_update) begin
      state_d = !cfg_active ? IDLE : cfg_mode == MODE_TRIGGERED ? ARMED : RUN;
      addr_d = (cfg_active && cfg_mode != MODE_TRIGGERED) ? cfg_start_offset : addr;
    end else if (state == ARMED && trigger && active_q) begin
      state_d = RUN;
      addr_d = start_q;
    end else if (state == RUN && advance && active_q) begin
      if (addr != end_q) addr_d = addr + OFFSET_WIDTH'(1);
      else if (mode_q == MODE_CONTINUOUS) begin
        addr_d = start_q;
        wrap_d = 1'b1;
      end else begin
        state_d = DONE;
        done_d = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      addr <= '0;
      addr_valid <= 1'b0;
      stopped <= 1'b1;
      wrapped <= 1'b0;
      done <= 1'b0;
      active_q <= 1'b0;
      mode_q <= MODE_CONTINUOUS;
      start_q <= '0;
      end_q <= '1;
    end else begin
      state <= state_d;
      addr <= addr_d;
      addr_valid <= state_d == RUN;
      stopped <= state_d == IDLE || state_d == DONE;
      wrapped <= wrap_d;
      done <= done_d;
      if (cfg_update) begin
        active_q <= cfg_active;
        mode_q <= cfg_mode == 2'd3 ? MODE_ONE_SHOT : cfg_mode;
        start_q <= cfg_start_offset;
        end_q <= cfg_end_offset;
      end
    end
  end
endmodule

// File: rtl/piradip_axis_sample_buffer_seq.sv
// piradip_axis_sample_buffer_seq: N independent sample-address sequencers sharing one config snapshot strobe
module piradip_axis_sample_buffer_seq
  import piradip_sample_buffer::*;
#(
  parameter int NCHANNELS    = 4,
  parameter int OFFSET_WIDTH = 5
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              cfg_update,
  input  logic [NCHANNELS-1:0]              cfg_active,
  input  logic [2*NCHANNELS-1:0]            cfg_mode,
  input  logic [NCHANNELS*OFFSET_WIDTH-1:0] cfg_start_offset,
  input  logic [NCHANNELS*OFFSET_WIDTH-1:0] cfg_end_offset,
  input  logic [NCHANNELS-1:0]              trigger,
  input  logic [NCHANNELS-1:0]              advance,
  output logic [NCHANNELS*OFFSET_WIDTH-1:0] addr,
  output logic [NCHANNELS-1:0]              addr_valid,
  output logic [NCHANNELS-1:0]              stopped,
  output logic [NCHANNELS-1:0]              wrapped,
  output logic [NCHANNELS-1:0]              done
);
  for (genvar i = 0; i < NCHANNELS; i++) begin : g_chan
    piradip_sample_buffer_seq_chan #(.OFFSET_WIDTH(OFFSET_WIDTH)) u_chan (
      .clk(clk),
      .rst(rst),
      .cfg_update(cfg_update),
      .cfg_active(cfg_active[i]),
      .cfg_mode(cfg_mode[2*i +: 2]),
      .cfg_start_offset(cfg_start_offset[i*OFFSET_WIDTH +: OFFSET_WIDTH]),
      .cfg_end_offset(cfg_end_offset[i*OFFSET_WIDTH +: OFFSET_WIDTH]),
      .trigger(trigger[i]),
      .advance(advance[i]),
      .addr(addr[i*OFFSET_WIDTH +: OFFSET_WIDTH]),
      .addr_valid(addr_valid[i]),
      .stopped(stopped[i]),
      .wrapped(wrapped[i]),
      .done(done[i])
    );
  end
endmodule

// File: tb/tb_piradip_axis_sample_buffer_seq.sv
// tb_piradip_axis_sample_buffer_seq: directed and random stimulus checked against a window-position model
module tb_piradip_axis_sample_buffer_seq;
  localparam int N = 4;
  localparam int W = 5;
  localparam int D = 1 << W;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cfg_update = 1'b0;
  logic [N-1:0] cfg_active = '0;
  logic [2*N-1:0] cfg_mode = '0;
  logic [N*W-1:0] cfg_start_offset = '0;
  logic [N*W-1:0] cfg_end_offset = '0;
  logic [N-1:0] trigger = '0;
  logic [N-1:0] advance = '0;
  logic [N*W-1:0] addr;
  logic [N-1:0] addr_valid, stopped, wrapped, done;
  int checks = 0;
  int failures = 0;
  int ms[N];
  int mpos[N];
  int mmode[N];
  int mstart[N];
  int mend[N];
  int maddr[N];
  bit mwrap[N];
  bit mdone[N];

  piradip_axis_sample_buffer_seq #(.NCHANNELS(N), .OFFSET_WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .cfg_update(cfg_update),
    .cfg_active(cfg_active),
    .cfg_mode(cfg_mode),
    .cfg_start_offset(cfg_start_offset),
    .cfg_end_offset(cfg_end_offset),
    .trigger(trigger),
    .advance(advance),
    .addr(addr),
    .addr_valid(addr_valid),
    .stopped(stopped),
    .wrapped(wrapped),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int c, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s ch%0d got=%0h exp=%0h", tag, c, got, exp);
    end
  endtask

  function automatic logic [31:0] a_of(input int c);
    return 32'(addr[c*W +: W]);
  endfunction

  // Model: state 0 idle, 1 armed, 2 run, 3 done; address is start plus window position.
  task automatic model_step();
    for (int c = 0; c < N; c++) begin
      mwrap[c] = 0;
      mdone[c] = 0;
      if (rst) begin
        ms[c] = 0; mpos[c] = 0; maddr[c] = 0; mmode[c] = 0; mstart[c] = 0; mend[c] = D - 1;
      end else if (cfg_update) begin
        mmode[c] = cfg_mode[2*c +: 2] == 2'd3 ? 1 : int'(cfg_mode[2*c +: 2]);
        mstart[c] = int'(cfg_start_offset[c*W +: W]);
        mend[c] = int'(cfg_end_offset[c*W +: W]);
        if (!cfg_active[c]) ms[c] = 0;
        else if (mmode[c] == 2) ms[c] = 1;
        else begin ms[c] = 2; mpos[c] = 0; maddr[c] = mstart[c]; end
      end else if (ms[c] == 1 && trigger[c]) begin
        ms[c] = 2; mpos[c] = 0; maddr[c] = mstart[c];
      end else if (ms[c] == 2 && advance[c]) begin
        int len = ((mend[c] - mstart[c] + D) % D) + 1;
        mpos[c]++;
        if (mpos[c] == len) begin
          if (mmode[c] == 0) begin mpos[c] = 0; mwrap[c] = 1; end
          else begin ms[c] = 3; mpos[c] = len - 1; mdone[c] = 1; end
        end
        maddr[c] = (mstart[c] + mpos[c]) % D;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    for (int c = 0; c < N; c++) begin
      chk("addr", c, a_of(c), 32'(maddr[c]));
      chk("addr_valid", c, 32'(addr_valid[c]), 32'(ms[c] == 2));
      chk("stopped", c, 32'(stopped[c]), 32'(ms[c] == 0 || ms[c] == 3));
      chk("wrapped", c, 32'(wrapped[c]), 32'(mwrap[c]));
      chk("done", c, 32'(done[c]), 32'(mdone[c]));
    end
    cfg_update = 0;
    trigger = '0;
    advance = '0;
  endtask

  task automatic set_cfg(input int c, input bit act, input int mode, input int s, input int e);
    cfg_active[c] = act;
    cfg_mode[2*c +: 2] = 2'(mode);
    cfg_start_offset[c*W +: W] = W'(s);
    cfg_end_offset[c*W +: W] = W'(e);
  endtask

  task automatic clear_cfg();
    for (int c = 0; c < N; c++) set_cfg(c, 0, 0, 0, 0);
  endtask

  initial begin
    tick();
    tick();
    rst = 0;
    chk("reset_addr", 0, 32'(addr), 32'h0);
    chk("reset_stopped", 0, 32'(stopped), 32'hf);
    chk("reset_valid", 0, 32'(addr_valid), 32'h0);
    tick();

    // Continuous wrap 3..6
    clear_cfg();
    set_cfg(0, 1, 0, 3, 6);
    cfg_update = 1;
    tick();
    chk("cont_start", 0, a_of(0), 32'd3);
    for (int k = 1; k <= 10; k++) begin
      advance[0] = 1;
      tick();
      chk("cont_addr", 0, a_of(0), 32'(3 + k % 4));
      chk("cont_wrap", 0, 32'(wrapped[0]), 32'(k % 4 == 0));
      chk("cont_nodone", 0, 32'(done[0]), 32'd0);
    end

    // One-shot across zero 30..1
    set_cfg(0, 1, 1, 30, 1);
    cfg_update = 1;
    tick();
    chk("os_start", 0, a_of(0), 32'd30);
    for (int k = 1; k <= 4; k++) begin
      advance[0] = 1;
      tick();
      chk("os_done", 0, 32'(done[0]), 32'(k == 4));
    end
    chk("os_hold", 0, a_of(0), 32'd1);
    chk("os_stopped", 0, 32'(stopped[0]), 32'd1);
    advance[0] = 1;
    tick();
    chk("os_after", 0, a_of(0), 32'd1);
    chk("os_done_fall", 0, 32'(done[0]), 32'd0);

    // Triggered arm on ch2
    clear_cfg();
    set_cfg(2, 1, 2, 12, 20);
    cfg_update = 1;
    tick();
    for (int k = 0; k < 5; k++) begin
      advance[2] = 1;
      tick();
      chk("armed_idle", 2, 32'(addr_valid[2]), 32'd0);
    end
    trigger[2] = 1;
    tick();
    chk("trig_valid", 2, 32'(addr_valid[2]), 32'd1);
    chk("trig_addr", 2, a_of(2), 32'd12);
    advance[2] = 1;
    tick();
    trigger[2] = 1;
    tick();
    chk("retrig_ignored", 2, a_of(2), 32'd13);

    // Collisions
    set_cfg(2, 1, 2, 4, 9);
    cfg_update = 1;
    trigger[2] = 1;
    tick();
    chk("coll_armed", 2, 32'(addr_valid[2]), 32'd0);
    set_cfg(2, 1, 0, 4, 9);
    cfg_update = 1;
    advance[2] = 1;
    tick();
    chk("coll_adv", 2, a_of(2), 32'd4);

    // Multi-channel
    clear_cfg();
    set_cfg(0, 1, 0, 0, 3);
    set_cfg(1, 1, 1, 8, 9);
    cfg_update = 1;
    tick();
    for (int k = 1; k <= 6; k++) begin
      advance[1:0] = 2'b11;
      tick();
      chk("multi_ch1_done", 1, 32'(done[1]), 32'(k == 2));
      chk("multi_ch0_addr", 0, a_of(0), 32'(k % 4));
    end
    set_cfg(0, 0, 0, 0, 3);
    cfg_update = 1;
    tick();
    chk("deact_stopped", 0, 32'(stopped[0]), 32'd1);

    // Reset mid-run with cfg inputs discarded
    clear_cfg();
    set_cfg(0, 1, 0, 0, 15);
    cfg_update = 1;
    tick();
    for (int k = 0; k < 5; k++) begin
      advance[0] = 1;
      tick();
    end
    chk("pre_rst_addr", 0, a_of(0), 32'd5);
    rst = 1;
    cfg_update = 1;
    advance[0] = 1;
    tick();
    rst = 0;
    chk("rst_addr", 0, a_of(0), 32'd0);
    chk("rst_stopped", 0, 32'(stopped[0]), 32'd1);
    chk("rst_nodone", 0, 32'(done[0]), 32'd0);
    clear_cfg();
    cfg_update = 1;
    tick();
    chk("rst_idle", 0, 32'(addr_valid[0]), 32'd0);

    // Random phase
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 9) == 0) begin
        for (int c = 0; c < N; c++)
          set_cfg(c, 1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, D - 1)), int'($urandom_range(0, D - 1)));
        cfg_update = 1;
      end
      rst = $urandom_range(0, 99) == 0;
      trigger = N'($urandom);
      advance = N'($urandom);
      tick();
    end
    rst = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
